// File: rtl/mesh_input_sequencer_pkg.sv
// Shared types and default sizes for the mesh input sequencer.
package mesh_input_sequencer_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_LANES  = 4;
    localparam int VEC_CNT_W  = 16;

endpackage

// File: rtl/seq_drain_counter.sv
// Loadable down-counter; zero_o flags that the count is zero after the coming edge.
module seq_drain_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mesh_input_sequencer.sv
// Packs upstream words into skewed systolic vectors: FILL lanes, one-cycle LOAD strobe,
// then DRAIN for row_idx+LANES cycles before accepting the next vector.
module mesh_input_sequencer
    import mesh_input_sequencer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int LANES  = DEF_LANES,
    parameter int ROWS   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    input  logic                      in_last,
    output logic [LANES*WORD_W-1:0]   systolic_inputs,
    output logic [LANES-1:0]          delay_row,
    output logic                      load,
    output logic                      systolic,
    output logic                      busy,
    output logic [VEC_CNT_W-1:0]      vec_count
);

    localparam int PTR_W = $clog2(LANES);
    localparam int CNT_W = PTR_W + 1;

    seq_state_e             state_q, state_d;
    logic                   run_q;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       row_q, row_d;
    logic                   last_q, last_d;
    logic [LANES-1:0]       delay_row_q, delay_row_d;
    logic [VEC_CNT_W-1:0]   vec_count_q, vec_count_d;

    logic                   accept;
    logic                   complete;
    logic [LANES-1:0]       lane_sel;
    logic [WORD_W-1:0]      fill_q [LANES];
    logic [WORD_W-1:0]      vec_q  [LANES];

    logic                   cnt_load;
    logic                   cnt_dec;
    logic [CNT_W-1:0]       cnt_value;
    logic                   cnt_zero;

    // run_q holds in_ready and systolic low until the first edge after reset release.
    assign in_ready = run_q && (state_q == FILL);
    assign accept   = in_ready && in_valid;
    assign complete = accept && (in_last || (wr_ptr_q == PTR_W'(LANES - 1)));

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_sel[gi] = accept && (wr_ptr_q == PTR_W'(LANES - 1 - gi));
            assign systolic_inputs[gi*WORD_W +: WORD_W] = vec_q[gi];

            // The fill buffer is cleared as it is handed off, so the next FILL starts from zero.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    fill_q[gi] <= '0;
                    vec_q[gi]  <= '0;
                end else if (complete) begin
                    fill_q[gi] <= '0;
                    vec_q[gi]  <= lane_sel[gi] ? in_data : fill_q[gi];
                end else if (lane_sel[gi]) begin
                    fill_q[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        row_d       = row_q;
        last_d      = last_q;
        delay_row_d = delay_row_q;
        vec_count_d = vec_count_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_value   = CNT_W'(row_q) + CNT_W'(LANES);
        case (state_q)
            FILL: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (complete) begin
                    state_d     = LOAD;
                    wr_ptr_d    = '0;
                    last_d      = in_last;
                    delay_row_d = LANES'(1) << row_q;
                    vec_count_d = vec_count_q + VEC_CNT_W'(1);
                end
            end
            LOAD: begin
                state_d  = DRAIN;
                cnt_load = 1'b1;
                if (last_q || (row_q == PTR_W'(ROWS - 1))) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + PTR_W'(1);
                end
            end
            DRAIN: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            run_q       <= 1'b0;
            wr_ptr_q    <= '0;
            row_q       <= '0;
            last_q      <= 1'b0;
            delay_row_q <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            row_q       <= row_d;
            last_q      <= last_d;
            delay_row_q <= delay_row_d;
            vec_count_q <= vec_count_d;
        end
    end

    seq_drain_counter #(
        .CNT_W (CNT_W)
    ) u_drain (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .dec_i   (cnt_dec),
        .zero_o  (cnt_zero)
    );

    assign load      = (state_q == LOAD);
    assign busy      = (state_q != FILL);
    assign systolic  = run_q;
    assign delay_row = delay_row_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_mesh_input_sequencer.sv
// Directed bench for mesh_input_sequencer with hand-computed vectors, skews and drain lengths.
module tb_mesh_input_sequencer;

    localparam int W = 32;
    localparam int L = 4;
    localparam int R = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             in_last = 1'b0;
    logic [L*W-1:0]   systolic_inputs;
    logic [L-1:0]     delay_row;
    logic             load;
    logic             systolic;
    logic             busy;
    logic [15:0]      vec_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_row  = 0;
    logic [15:0] exp_vc = '0;

    mesh_input_sequencer #(.WORD_W(W), .LANES(L), .ROWS(R)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .systolic_inputs (systolic_inputs),
        .delay_row       (delay_row),
        .load            (load),
        .systolic        (systolic),
        .busy            (busy),
        .vec_count       (vec_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives n beats base, base+1, ... on consecutive cycles; returns at the negedge of the LOAD cycle.
    task automatic issue(input int n, input logic [W-1:0] base, input bit with_last, input bit hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = base + W'(i);
            in_last  = with_last && (i == n - 1);
        end
        @(negedge clk);
        in_last = 1'b0;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(output int len);
        len = 0;
        @(negedge clk);
        while (busy && !load && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_row = 0;
        exp_vc  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (systolic !== 1'b0) begin n_fail++; $display("FAIL rst_systolic: got %b want 0", systolic); end
        n_checks++; if ({load, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_load_busy: got %b want 00", {load, busy}); end
        n_checks++; if (vec_count !== 16'h0) begin n_fail++; $display("FAIL rst_vec_count: got %h want 0000", vec_count); end
        n_checks++; if (delay_row !== 4'b0) begin n_fail++; $display("FAIL rst_delay_row: got %b want 0000", delay_row); end
        n_checks++; if (systolic_inputs !== '0) begin n_fail++; $display("FAIL rst_inputs: got %h want 0", systolic_inputs); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_before_edge: got %b want 0", in_ready); end
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        n_checks++; if (systolic !== 1'b1) begin n_fail++; $display("FAIL rel_systolic: got %b want 1", systolic); end
        $display("reset: in_ready=%b systolic=%b", in_ready, systolic);
    endtask

    task automatic test_full_vector();
        int len;
        logic [L*W-1:0] exp_v;
        exp_v = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        issue(4, 32'hA0, 1'b0, 1'b0);
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL full_load: got %b want 1", load); end
        n_checks++; if (systolic_inputs !== exp_v) begin n_fail++; $display("FAIL full_data: got %h want %h", systolic_inputs, exp_v); end
        n_checks++; if (delay_row !== 4'b0001) begin n_fail++; $display("FAIL full_delay: got %b want 0001", delay_row); end
        n_checks++; if (vec_count !== 16'd1) begin n_fail++; $display("FAIL full_vec_count: got %0d want 1", vec_count); end
        n_checks++; if ({in_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL full_ready_busy: got %b want 01", {in_ready, busy}); end
        drain(len);
        n_checks++; if (len !== 4) begin n_fail++; $display("FAIL full_drain: got %0d want 4", len); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_refill_ready: got %b want 1", in_ready); end
        $display("full vector: data=%h delay=%b count=%0d drain=%0d", systolic_inputs, delay_row, vec_count, len);
    endtask

    task automatic test_row_rotation();
        int len;
        logic [W-1:0] base;
        logic [L*W-1:0] exp_v;
        logic [3:0] exp_d [5];
        int exp_len [5];
        exp_d   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_len = '{4, 5, 6, 7, 4};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            base  = W'(32'h10 * (i + 1));
            exp_v = {base, base + 32'd1, base + 32'd2, base + 32'd3};
            issue(4, base, 1'b0, 1'b0);
            n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL rot_load[%0d]: got %b want 1", i, load); end
            n_checks++; if (systolic_inputs !== exp_v) begin n_fail++; $display("FAIL rot_data[%0d]: got %h want %h", i, systolic_inputs, exp_v); end
            n_checks++; if (delay_row !== exp_d[i]) begin n_fail++; $display("FAIL rot_delay[%0d]: got %b want %b", i, delay_row, exp_d[i]); end
            n_checks++; if (vec_count !== 16'(i + 1)) begin n_fail++; $display("FAIL rot_count[%0d]: got %0d want %0d", i, vec_count, i + 1); end
            drain(len);
            n_checks++; if (len !== exp_len[i]) begin n_fail++; $display("FAIL rot_drain[%0d]: got %0d want %0d", i, len, exp_len[i]); end
            $display("rotation %0d: delay=%b drain=%0d", i, delay_row, len);
        end
        exp_row = 1;
        exp_vc  = 16'd5;
    endtask

    task automatic test_short_tile();
        int len;
        logic [L*W-1:0] exp_v;
        exp_v = {32'hB0, 32'hB1, 32'h0, 32'h0};
        issue(2, 32'hB0, 1'b1, 1'b0);
        exp_vc++;
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL short_load: got %b want 1", load); end
        n_checks++; if (systolic_inputs !== exp_v) begin n_fail++; $display("FAIL short_data: got %h want %h", systolic_inputs, exp_v); end
        n_checks++; if (delay_row !== 4'(1 << exp_row)) begin n_fail++; $display("FAIL short_delay: got %b want %b", delay_row, 4'(1 << exp_row)); end
        n_checks++; if (vec_count !== exp_vc) begin n_fail++; $display("FAIL short_count: got %0d want %0d", vec_count, exp_vc); end
        drain(len);
        n_checks++; if (len !== exp_row + L) begin n_fail++; $display("FAIL short_drain: got %0d want %0d", len, exp_row + L); end
        $display("short tile: data=%h delay=%b drain=%0d", systolic_inputs, delay_row, len);
        exp_row = 0;
        exp_v = {32'hC0, 32'hC1, 32'hC2, 32'hC3};
        issue(4, 32'hC0, 1'b0, 1'b0);
        exp_vc++;
        n_checks++; if (systolic_inputs !== exp_v) begin n_fail++; $display("FAIL after_short_data: got %h want %h", systolic_inputs, exp_v); end
        n_checks++; if (delay_row !== 4'b0001) begin n_fail++; $display("FAIL after_short_delay: got %b want 0001", delay_row); end
        drain(len);
        n_checks++; if (len !== 4) begin n_fail++; $display("FAIL after_short_drain: got %0d want 4", len); end
        $display("after short: data=%h delay=%b drain=%0d", systolic_inputs, delay_row, len);
        exp_row = 1;
    endtask

    task automatic test_back_to_back();
        int len;
        logic [L*W-1:0] exp_v;
        exp_v = {32'hD0, 32'hD1, 32'hD2, 32'hD3};
        issue(4, 32'hD0, 1'b0, 1'b1);
        exp_vc++;
        in_data = 32'hEE;
        n_checks++; if (delay_row !== 4'(1 << exp_row)) begin n_fail++; $display("FAIL bp_delay: got %b want %b", delay_row, 4'(1 << exp_row)); end
        len = 0;
        while (busy && len < 40) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", len, in_ready); end
            n_checks++; if (systolic_inputs !== exp_v) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", len, systolic_inputs, exp_v); end
            len++;
            @(negedge clk);
        end
        n_checks++; if (len !== exp_row + L + 1) begin n_fail++; $display("FAIL bp_busy_len: got %0d want %0d", len, exp_row + L + 1); end
        $display("backpressure: held vector %h busy=%0d cycles", exp_v, len);
        exp_row = (exp_row + 1) % R;
        issue(3, 32'hE1, 1'b0, 1'b0);
        exp_vc++;
        exp_v = {32'hEE, 32'hE1, 32'hE2, 32'hE3};
        n_checks++; if (systolic_inputs !== exp_v) begin n_fail++; $display("FAIL bp_next_data: got %h want %h", systolic_inputs, exp_v); end
        n_checks++; if (vec_count !== exp_vc) begin n_fail++; $display("FAIL bp_next_count: got %0d want %0d", vec_count, exp_vc); end
        drain(len);
        n_checks++; if (len !== exp_row + L) begin n_fail++; $display("FAIL bp_next_drain: got %0d want %0d", len, exp_row + L); end
        $display("back-to-back: data=%h delay=%b drain=%0d", systolic_inputs, delay_row, len);
        exp_row = (exp_row + 1) % R;
    endtask

    task automatic test_reset_mid_drain();
        int len;
        issue(4, 32'h50, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({load, busy, in_ready, systolic} !== 4'b0000) begin n_fail++; $display("FAIL mid_flags: got %b want 0000", {load, busy, in_ready, systolic}); end
        n_checks++; if (vec_count !== 16'h0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", vec_count); end
        n_checks++; if ({systolic_inputs, delay_row} !== '0) begin n_fail++; $display("FAIL mid_outputs: got %h/%b want 0", systolic_inputs, delay_row); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(4, 32'h60, 1'b0, 1'b0);
        n_checks++; if (delay_row !== 4'b0001) begin n_fail++; $display("FAIL mid_fresh_delay: got %b want 0001", delay_row); end
        n_checks++; if (vec_count !== 16'd1) begin n_fail++; $display("FAIL mid_fresh_count: got %0d want 1", vec_count); end
        drain(len);
        n_checks++; if (len !== 4) begin n_fail++; $display("FAIL mid_fresh_drain: got %0d want 4", len); end
        $display("reset mid-drain: fresh delay=%b count=%0d drain=%0d", delay_row, vec_count, len);
        exp_row = 1;
        exp_vc  = 16'd1;
    endtask

    task automatic test_wrap();
        int len;
        logic [15:0] want [2];
        logic [W-1:0] base;
        logic [L*W-1:0] exp_v;
        want = '{16'hFFFF, 16'h0000};
        force dut.vec_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.vec_count_q;
        for (int i = 0; i < 2; i++) begin
            base  = W'(32'h70 + 32'h10 * i);
            exp_v = {base, base + 32'd1, base + 32'd2, base + 32'd3};
            issue(4, base, 1'b0, 1'b0);
            n_checks++; if (vec_count !== want[i]) begin n_fail++; $display("FAIL wrap_count[%0d]: got %h want %h", i, vec_count, want[i]); end
            n_checks++; if (systolic_inputs !== exp_v) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, systolic_inputs, exp_v); end
            n_checks++; if (delay_row !== 4'(1 << exp_row)) begin n_fail++; $display("FAIL wrap_delay[%0d]: got %b want %b", i, delay_row, 4'(1 << exp_row)); end
            drain(len);
            n_checks++; if (len !== exp_row + L) begin n_fail++; $display("FAIL wrap_drain[%0d]: got %0d want %0d", i, len, exp_row + L); end
            $display("wrap %0d: count=%h delay=%b drain=%0d", i, vec_count, delay_row, len);
            exp_row = (exp_row + 1) % R;
        end
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_row_rotation();
        test_short_tile();
        test_back_to_back();
        test_reset_mid_drain();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mesh_input_sequencer.md
MESH_INPUT_SEQUENCER -- requirements
Module: mesh_input_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, lane data width.
REQ-002 SHALL have parameter LANES, default 4, words per systolic vector (power of two, 2..16).
REQ-003 SHALL have parameter ROWS, default 4, mesh rows served by the delay_row rotation (1..LANES).
REQ-004 Ports, in order:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- in_data  in  WORD_W  upstream word.
- in_last  in  1  final word of a matrix tile.
- systolic_inputs  out  LANES x WORD_W  packed vector for the input interface.
- delay_row  out  LANES  one-hot skew code; bit k set means a k-cycle skew.
- load  out  1  one-cycle strobe that captures systolic_inputs and delay_row.
- systolic  out  1  mode select, 1 whenever reset is deasserted.
- busy  out  1  a vector is being loaded or drained.
- vec_count  out  16  vectors issued since reset, wrapping.

Function
REQ-005 SHALL implement a three-state FSM: FILL, LOAD, DRAIN.
REQ-006 FILL behaviour:
- in_ready=1.
- Each in_valid&in_ready beat writes the lane at index LANES-1-wr_ptr, so the first word lands in lane LANES-1, which is emitted first.
- wr_ptr then increments.
REQ-007 FILL->LOAD SHALL occur on the accepting beat where wr_ptr==LANES-1, or on an accepted beat with in_last=1.
REQ-008 On an in_last beat with wr_ptr<LANES-1, all unwritten lanes SHALL be zero in the issued vector.
REQ-009 LOAD behaviour:
- Lasts exactly one cycle: load=1, in_ready=0, busy=1.
- systolic_inputs and delay_row stay stable from this cycle until the next LOAD.
REQ-010 delay_row SHALL equal 1<<row_idx. row_idx starts at 0 and increments per issued vector, wrapping ROWS-1->0.
REQ-011 If the vector carried in_last, row_idx SHALL return to 0 after that LOAD.
REQ-012 DRAIN behaviour:
- in_ready=0, busy=1.
- The drain counter loads row_idx+LANES on entry and decrements each cycle.
- DRAIN->FILL when the counter reaches 0.
- Total DRAIN length is row_idx+LANES cycles, using the row_idx of the issued vector.
REQ-013 On FILL re-entry, wr_ptr=0 and all lanes SHALL be cleared to zero.
REQ-014 vec_count SHALL increment in the LOAD cycle, wrapping 0xFFFF->0.
REQ-015 Latency: the LOAD cycle SHALL be the cycle immediately after the completing beat.
REQ-016 in_valid while in_ready=0 SHALL be ignored; the upstream holds data (valid/ready rule).
REQ-017 in_ready SHALL be a registered-state decode only, with no combinational path from in_valid.

Reset
REQ-018 Asynchronous assertion (reset=0) SHALL force:
- state=FILL; wr_ptr, row_idx, drain counter = 0.
- systolic_inputs, delay_row, load, busy, vec_count, systolic = 0.
- in_ready = 0.
REQ-019 Deassertion is synchronous to clk. in_ready=1 and systolic=1 from the first clock edge after release.
REQ-020 Reset mid-LOAD or mid-DRAIN SHALL abort the vector with no load strobe, and SHALL NOT increment vec_count.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state enum (FILL, LOAD, DRAIN);
- WORD_W and LANES defaults;
- the vec_count width constant.
REQ-022 The FSM, packer and counters SHALL form one module. The only sub-module is seq_drain_counter, a loadable down-counter with a zero flag.

Verification
REQ-023 Full vector:
- Stimulus: after reset, beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
- Response, next cycle: load=1; lanes[3..0]=A0,A1,A2,A3; delay_row=0001; vec_count=1.
- Then busy for 4 drain cycles.
REQ-024 Row rotation:
- Stimulus: five full vectors back-to-back, ROWS=4.
- Response: delay_row 0001,0010,0100,1000,0001.
- Drain lengths 4,5,6,7,4.
REQ-025 Short tile:
- Stimulus: beats 0xB0,0xB1 with in_last on 0xB1.
- Response: lanes[3..0]=B0,B1,0,0; load next cycle.
- Following vector has delay_row=0001.
REQ-026 Backpressure: in_valid held high during LOAD/DRAIN; no beat is consumed while in_ready=0, and data is unchanged.
REQ-027 Reset mid-DRAIN:
- Stimulus: assert reset 2 cycles into DRAIN.
- Response: outputs zero immediately with no clock needed, vec_count=0.
- After release, a fresh vector issues with delay_row=0001.
REQ-028 Wrap: force 65,536 vectors; vec_count returns to 0 with no other disturbance.
